program_loader: RTL and testbench
=================================

# program_loader

Writer-side companion to the instruction memory. It takes a little-endian byte stream over a valid/ready handshake, typically from a UART receiver, and packs it into 32-bit words. It writes the words into the program memory through its byte-address / write-enable / write-data port, and holds the CPU core in reset until the image is complete. It sits between the byte source and `program_memory`, and drives the core's `reset_n`.

## Interface
- `ADDR_WIDTH`, default 5: byte-address width of program memory. Capacity is `2^(ADDR_WIDTH-2)` words (8 by default).
- `clk` input 1: single clock; all logic on posedge.
- `reset_n` input 1: reset is synchronous and active-low.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` valid.
- `rx_ready` output 1: loader accepts a byte this cycle. A transfer happens when `rx_valid && rx_ready` at a posedge.
- `mem_byte_address` output ADDR_WIDTH: word-aligned write address; bits [1:0] are always 0.
- `mem_write_enable` output 1: one-cycle write strobe.
- `mem_write_data` output 32: assembled word.
- `cpu_reset_n` output 1: core reset; low while loading.
- `busy` output 1: high from the first accepted byte until DONE or ERROR.
- `done` output 1: image loaded; sticky until `reset_n`.
- `error` output 1: load failed; sticky until `reset_n`.

## Operation
- Stream format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then 4·N payload bytes with each word LSB first. With `LOADER_CHECKSUM_EN`, one checksum byte follows.
- States and transitions:
  - CNT_LO: accept byte → CNT_HI.
  - CNT_HI: accept byte. If N > capacity → ERROR. Else if N == 0 → CHECK or DONE. Else → DATA.
  - DATA: accept 4 bytes into `mem_write_data[8k+7:8k]`, where k is the byte index 0..3. After byte 3 → WRITE.
  - WRITE: `mem_write_enable`=1 for exactly one cycle at the current address; `rx_ready`=0. Next cycle the address advances by 4. If words written == N → CHECK or DONE, else → DATA.
  - CHECK (macro only): accept one byte. If it matches → DONE, else → ERROR.
  - DONE: `cpu_reset_n`=1, `done`=1, `rx_ready`=0. Further bytes are not accepted.
  - ERROR: `cpu_reset_n`=0, `error`=1, `rx_ready`=0. Only `reset_n` exits ERROR.
- `rx_ready` is 1 in CNT_LO, CNT_HI, DATA and CHECK; 0 elsewhere.
- `rx_valid` low stalls any state indefinitely; the partial word and counters are held.
- Address arithmetic is unsigned. N ≤ capacity guarantees no wrap. The address never exceeds `4·(N-1)`.

## Timing
- Reset values (first posedge with `reset_n`=0, then held): state CNT_LO, `rx_ready`=1, `mem_byte_address`=0, `mem_write_enable`=0, `mem_write_data`=0, `cpu_reset_n`=0, `busy`=0, `done`=0, `error`=0. The checksum accumulator is reset to 0x00.
- All outputs except `rx_ready` are registered. `rx_ready` decodes the state register directly, with no input path.
- `mem_write_enable` is high in the cycle immediately after the posedge that accepted a word's 4th byte.
- Throughput: 1 byte per cycle, plus 1 WRITE cycle per word. Minimum load time is 2 + 5·N cycles, plus 1 with checksum.
- `cpu_reset_n` and `done` rise in the cycle after entering DONE, which is the cycle after the last WRITE (or after the CHECK byte).
- Asserting `reset_n` in any state, including mid-word or during WRITE, aborts the load. Words already written stay in memory. The partial word is discarded.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Running XOR of every accepted byte, including both count bytes.
  - The CHECK state expects the next byte to equal this XOR.
  - On mismatch → ERROR. The core stays in reset even though memory was written.
- `LOADER_CHECKSUM_EN` undefined: the CHECK state and accumulator are absent, and the last WRITE (or N == 0) goes directly to DONE.

## Test plan
- Basic load (macro off): send bytes 02 00 13 00 00 00 93 00 10 00 → writes 0x00000013 @0 and 0x00100093 @4. Each strobe lasts one cycle. `cpu_reset_n` rises 1 cycle after the second write and `done`=1.
- Checksum (macro on): the same stream + 0x92 → DONE. The same stream + 0x93 → `error`=1 and `cpu_reset_n` stays 0.
- Backpressure/stalls: send the same stream with `rx_valid` toggled randomly → identical writes. `rx_ready`=0 exactly in WRITE cycles. No byte is lost or duplicated.
- Bounds: N=8 with `ADDR_WIDTH`=5 → last write @0x1C, then DONE. N=9 → ERROR immediately after COUNT_HI, with no writes.
- Empty image: bytes 00 00 → no `mem_write_enable`, DONE 1 cycle later.
- Reset mid-operation: assert `reset_n`=0 after 2 payload bytes → all outputs return to reset values. A fresh full stream then loads correctly from address 0.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus shared by the loader and its
// environment.
//   rx_data/rx_valid/rx_ready : little-endian byte stream, transfer on valid && ready
//   mem_byte_address          : word-aligned byte address into program memory
//   mem_write_enable          : one-cycle write strobe
//   mem_write_data            : assembled 32-bit word
// Modports: master = loader side (drives ready and the memory bus),
//           slave  = byte source / memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_byte_address;
  logic                  mem_write_enable;
  logic [31:0]           mem_write_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_byte_address,
    output mem_write_enable,
    output mem_write_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_byte_address,
    input  mem_write_enable,
    input  mem_write_data
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: packs a little-endian byte stream (COUNT_LO, COUNT_HI, then
// 4*N payload bytes) into 32-bit words, writes them into program memory and
// holds the core in reset until the image is complete.
// Optional feature macro LOADER_CHECKSUM_EN: a trailing byte must equal the
// XOR of every previously accepted byte, otherwise the load fails.
// Ports:
//   clk         : clock, all logic on posedge
//   reset_n     : synchronous active-low reset
//   bus         : byte stream in, memory write bus out (program_loader_if.master)
//   cpu_reset_n : core reset, released only once the load has completed
//   busy        : load in progress (first accepted byte until done/error)
//   done        : image loaded, sticky until reset_n
//   error       : load failed, sticky until reset_n
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  program_loader_if.master bus,
  output logic             cpu_reset_n,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [16:0]           CapWords = 17'(1 << (ADDR_WIDTH - 2));
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    StCntLo,
    StCntHi,
    StData,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           words_q, words_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic        load_end;
  logic [15:0] n_full;

  // Ready is a pure state decode so the byte source never sees a comb path.
  always_comb begin
    bus.rx_ready = 1'b0;
    unique case (state_q)
      StCntLo, StCntHi, StData: bus.rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCheck:                  bus.rx_ready = 1'b1;
`endif
      default:                  bus.rx_ready = 1'b0;
    endcase
  end

  assign accept = bus.rx_valid & bus.rx_ready;
  assign n_full = {bus.rx_data, count_q[7:0]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    words_d     = words_q;
    byte_idx_d  = byte_idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_rst_n_d = cpu_rst_n_q;
    load_end    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (accept) csum_d = csum_q ^ bus.rx_data;
`endif

    unique case (state_q)
      StCntLo: begin
        if (accept) begin
          count_d[7:0] = bus.rx_data;
          busy_d       = 1'b1;
          state_d      = StCntHi;
        end
      end
      StCntHi: begin
        if (accept) begin
          count_d[15:8] = bus.rx_data;
          if ({1'b0, n_full} > CapWords) begin
            state_d = StError;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (n_full == 16'd0) begin
            load_end = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          data_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        words_d = words_q + 16'd1;
        if (words_d == count_q) begin
          // Address stays on the last word so it never exceeds 4*(N-1).
          load_end = 1'b1;
        end else begin
          addr_d  = addr_q + AddrStep;
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          busy_d = 1'b0;
          if (bus.rx_data == csum_q) begin
            state_d     = StDone;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = StError;
            error_d = 1'b1;
          end
        end
      end
`endif
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase

    if (load_end) begin
`ifdef LOADER_CHECKSUM_EN
      state_d     = StCheck;
`else
      state_d     = StDone;
      done_d      = 1'b1;
      cpu_rst_n_d = 1'b1;
      busy_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StCntLo;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q     <= '0;
      words_q     <= '0;
      byte_idx_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      count_q     <= count_d;
      words_q     <= words_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.mem_byte_address = addr_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_write_data   = data_q;
  assign cpu_reset_n          = cpu_rst_n_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int Cap = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_reset_n, busy, done, error;

  program_loader_if #(.ADDR_WIDTH(5)) bus ();

  program_loader #(.ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Behavioural model: tracks how many bytes of the stream were consumed and
  // derives every output from the stream format, not from any state encoding.
  bit          m_valid = 0;
  int          m_nb, m_n, m_words;
  bit          m_wr, m_done, m_err, m_bus_cmp;
  logic [7:0]  m_csum;
  logic [31:0] m_word, m_data;
  int          m_addr;

  function automatic bit m_ready();
    return !m_wr && !m_done && !m_err;
  endfunction

  initial begin : model
    int b, k;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_valid = 1; m_nb = 0; m_n = 0; m_words = 0; m_wr = 0; m_done = 0;
        m_err = 0; m_csum = 8'h00; m_word = 0; m_data = 0; m_addr = 0; m_bus_cmp = 1;
      end else if (m_valid) begin
        m_bus_cmp = 0;
        if (m_wr) begin
          m_wr = 0;
          m_words++;
`ifndef LOADER_CHECKSUM_EN
          if (m_words == m_n) m_done = 1;
`endif
        end else if (bus.rx_valid && m_ready()) begin
          d = bus.rx_data;
          b = m_nb;
          m_nb++;
          if (b == 0) begin
            m_n = int'(d);
          end else if (b == 1) begin
            m_n = m_n + (int'(d) << 8);
            if (m_n > Cap) m_err = 1;
`ifndef LOADER_CHECKSUM_EN
            else if (m_n == 0) m_done = 1;
`endif
          end else if (b < 2 + 4 * m_n) begin
            k = (b - 2) % 4;
            m_word[8*k +: 8] = d;
            if (k == 3) begin
              m_wr = 1; m_bus_cmp = 1;
              m_addr = 4 * ((b - 2) / 4);
              m_data = m_word;
            end
          end else begin
            if (d == m_csum) m_done = 1;
            else m_err = 1;
          end
          m_csum = m_csum ^ d;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("rx_ready", 32'(bus.rx_ready), 32'(m_ready()));
        check("mem_write_enable", 32'(bus.mem_write_enable), 32'(m_wr));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("cpu_reset_n", 32'(cpu_reset_n), 32'(m_done));
        check("busy", 32'(busy), 32'(m_nb > 0 && !m_done && !m_err));
        if (m_bus_cmp) begin
          check("mem_byte_address", 32'(bus.mem_byte_address), 32'(m_addr));
          check("mem_write_data", bus.mem_write_data, m_data);
        end
      end
    end
  end

  // Log of observed writes, for literal checks.
  logic [4:0]  log_addr[64];
  logic [31:0] log_data[64];
  int          wn = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.mem_write_enable && wn < 64) begin
        log_addr[wn] = bus.mem_byte_address;
        log_data[wn] = bus.mem_write_data;
        wn++;
      end
    end
  end

  logic [7:0] stim[$];

  task automatic send_byte(input logic [7:0] d, input bit stall);
    int  guard;
    bit  r;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      r = bus.rx_ready;
      @(posedge clk); #1;
      if (r) break;
      guard++;
      if (guard > 20) begin
        n_checks++;
        $display("FAIL accept_timeout: byte %h never accepted within 20 cycles", d);
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream(input bit stall);
    foreach (stim[i]) send_byte(stim[i], stall);
  endtask

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stim[i]) x = x ^ stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    while (!(done || error)) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        n_checks++;
        $display("FAIL end_timeout: neither done nor error after 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_addr", 32'(bus.mem_byte_address), 32'd0);
    check("rst_we", 32'(bus.mem_write_enable), 32'd0);
    check("rst_data", bus.mem_write_data, 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic load_basic();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic check_basic_log(input int s);
    check("basic_write_count", 32'(wn - s), 32'd2);
    check("basic_w0_addr", 32'(log_addr[s]), 32'h0);
    check("basic_w0_data", log_data[s], 32'h00000013);
    check("basic_w1_addr", 32'(log_addr[s+1]), 32'h4);
    check("basic_w1_data", log_data[s+1], 32'h00100093);
  endtask

  initial begin : stimulus
    int s;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Basic load, no stalls
    s = wn;
    load_basic();
    add_csum();
    send_stream(0);
    wait_end();
    check_basic_log(s);
    check("basic_done", 32'(done), 32'd1);
    check("basic_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    // Bytes offered in DONE must be ignored
    bus.rx_data = 8'hFF; bus.rx_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b0;
    check("done_no_extra_writes", 32'(wn - s), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    check("csum_byte", 32'(stim[10]), 32'h92);
    // Wrong checksum
    do_reset();
    s = wn;
    load_basic();
    stim.push_back(8'h93);
    send_stream(0);
    wait_end();
    check("badsum_write_count", 32'(wn - s), 32'd2);
    check("badsum_error", 32'(error), 32'd1);
    check("badsum_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
`endif

    // Same stream with random stalls
    do_reset();
    s = wn;
    load_basic();
    add_csum();
    send_stream(1);
    wait_end();
    check_basic_log(s);
    check("stall_done", 32'(done), 32'd1);

    // Full capacity
    do_reset();
    s = wn;
    stim = '{8'h08, 8'h00};
    for (int i = 0; i < 32; i++) stim.push_back(8'(i * 7 + 1));
    add_csum();
    send_stream(1);
    wait_end();
    check("n8_write_count", 32'(wn - s), 32'd8);
    check("n8_last_addr", 32'(log_addr[s+7]), 32'h1C);
    check("n8_last_data", log_data[s+7], 32'hDAD3CCC5);
    check("n8_done", 32'(done), 32'd1);

    // Over capacity
    do_reset();
    s = wn;
    stim = '{8'h09, 8'h00};
    send_stream(0);
    wait_end();
    check("n9_write_count", 32'(wn - s), 32'd0);
    check("n9_error", 32'(error), 32'd1);
    check("n9_cpu_reset_n", 32'(cpu_reset_n), 32'd0);

    // Empty image
    do_reset();
    s = wn;
    stim = '{8'h00, 8'h00};
    add_csum();
    send_stream(0);
    wait_end();
    check("n0_write_count", 32'(wn - s), 32'd0);
    check("n0_done", 32'(done), 32'd1);

    // Reset mid-word, then a fresh load from address 0
    do_reset();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_stream(0);
    check("mid_busy", 32'(busy), 32'd1);
    do_reset();
    s = wn;
    load_basic();
    add_csum();
    send_stream(0);
    wait_end();
    check_basic_log(s);
    check("mid_done", 32'(done), 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
